// File: rtl/barrel_shifter_pipe_if.sv
// Stream interface of the pipelined barrel shifter.
// slave  : the shifter (consumes the input side, drives the output side)
// master : the environment (drives operands and downstream ready)
interface barrel_shifter_pipe_if #(
  parameter int Width = 16
) ();
  localparam int AmtW = $clog2(Width);

  logic              valid_i;
  logic              ready_o;
  logic [Width-1:0]  x_i;
  logic [AmtW-1:0]   amount_i;
  logic [1:0]        mode_i;
  logic              valid_o;
  logic              ready_i;
  logic [Width-1:0]  y_o;

  modport slave (
    input  valid_i, x_i, amount_i, mode_i, ready_i,
    output ready_o, valid_o, y_o
  );

  modport master (
    output valid_i, x_i, amount_i, mode_i, ready_i,
    input  ready_o, valid_o, y_o
  );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined multi-mode barrel shifter: ASR / LSR / LSL / ROR by 0..Width-1.
// Stage k shifts by 2^k when amount bit k is set; one register per stage,
// so latency is $clog2(Width) cycles at one item per cycle.
// Global-enable pipeline: a stalled output freezes every stage.
// Optional feature macro ROUND_EN: round-half-up on ASR via a per-stage guard bit.
module barrel_shifter_pipe #(
  parameter int Width = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  barrel_shifter_pipe_if.slave  bus
);
  localparam int AmtW = $clog2(Width);
  localparam logic [1:0] MODE_ASR = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;

  if (Width < 4 || (Width & (Width - 1)) != 0) begin : g_bad_width
    $error("barrel_shifter_pipe: Width must be a power of two >= 4");
  end

  // Whole pipe advances unless the output item is blocked downstream
  logic w_en;
  assign w_en        = !(bus.valid_o && !bus.ready_i);
  assign bus.ready_o = w_en;

  function automatic logic [Width-1:0] shift_by(input logic [Width-1:0] d,
                                                input logic [1:0] m, input int sh);
    logic [Width-1:0] r;
    case (m)
      MODE_ASR: r = $signed(d) >>> sh;   // MSB is still the original sign bit
      MODE_LSR: r = d >> sh;
      MODE_LSL: r = d << sh;
      default:  r = (d >> sh) | (d << (Width - sh));
    endcase
    return r;
  endfunction

  for (genvar k = 0; k < AmtW; k++) begin : g_stage
    localparam int SH = 1 << k;
    localparam int AW = AmtW - k;   // amount bits still unconsumed at this stage

    logic [Width-1:0] w_din, w_sh, w_res;
    logic [AW-1:0]    w_ain;
    logic [1:0]       w_min;
    logic             w_vin;
    logic [Width-1:0] r_data;
    logic             r_vld;
`ifdef ROUND_EN
    logic             w_gin, w_gnew;
`endif

    if (k == 0) begin : g_src
      assign w_din = bus.x_i;
      assign w_ain = bus.amount_i;
      assign w_min = bus.mode_i;
      assign w_vin = bus.valid_i;
`ifdef ROUND_EN
      assign w_gin = 1'b0;
`endif
    end else begin : g_chain
      assign w_din = g_stage[k-1].r_data;
      assign w_ain = g_stage[k-1].g_fwd.r_amt;
      assign w_min = g_stage[k-1].g_fwd.r_mode;
      assign w_vin = g_stage[k-1].r_vld;
`ifdef ROUND_EN
      assign w_gin = g_stage[k-1].g_fwd.r_guard;
`endif
    end

    assign w_sh = w_ain[0] ? shift_by(w_din, w_min, SH) : w_din;

`ifdef ROUND_EN
    // Guard = last bit shifted out below the LSB; adding it rounds half-up
    assign w_gnew = w_ain[0] ? w_din[SH-1] : w_gin;
    if (k == AmtW - 1) begin : g_round
      assign w_res = (w_min == MODE_ASR) ? w_sh + Width'(w_gnew) : w_sh;
    end else begin : g_pass
      assign w_res = w_sh;
    end
`else
    assign w_res = w_sh;
`endif

    // Stage register: flush clears valid even when stalled; data frozen on stall/flush
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_vld  <= 1'b0;
        r_data <= '0;
      end else begin
        if (flush_i)   r_vld <= 1'b0;
        else if (w_en) r_vld <= w_vin;
        if (w_en && !flush_i) r_data <= w_res;
      end
    end

    if (k < AmtW - 1) begin : g_fwd
      logic [AW-2:0] r_amt;
      logic [1:0]    r_mode;
`ifdef ROUND_EN
      logic          r_guard;
`endif
      // Forward the remaining amount bits, mode (and guard) alongside the data
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_amt   <= '0;
          r_mode  <= '0;
`ifdef ROUND_EN
          r_guard <= 1'b0;
`endif
        end else if (w_en && !flush_i) begin
          r_amt   <= w_ain[AW-1:1];
          r_mode  <= w_min;
`ifdef ROUND_EN
          r_guard <= w_gnew;
`endif
        end
      end
    end
  end

  assign bus.valid_o = g_stage[AmtW-1].r_vld;
  assign bus.y_o     = g_stage[AmtW-1].r_data;
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe at Width=16 (latency 4).
module tb_barrel_shifter_pipe;
  localparam logic [1:0] ASR = 2'b00, LSR = 2'b01, LSL = 2'b10, ROR = 2'b11;
`ifdef ROUND_EN
  localparam logic [15:0] E_7FFF = 16'h0001, E_0007 = 16'h0004, E_FFFB = 16'hFFFE;
`else
  localparam logic [15:0] E_7FFF = 16'h0000, E_0007 = 16'h0003, E_FFFB = 16'hFFFD;
`endif

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  int   tests = 0, fails = 0;

  barrel_shifter_pipe_if #(.Width(16)) bus ();
  barrel_shifter_pipe #(.Width(16)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Independent reference: wide integer arithmetic, no stage decomposition
  function automatic logic [15:0] model(input logic [15:0] x, input int amt, input logic [1:0] m);
    int sx;
    logic [31:0] xx;
    case (m)
      ASR: begin
        sx = $signed(x);
`ifdef ROUND_EN
        if (amt > 0) sx = sx + (1 << (amt - 1));
`endif
        return 16'(sx >>> amt);
      end
      LSR: return 16'(x >> amt);
      LSL: return 16'(x << amt);
      default: begin
        xx = {x, x};
        return 16'(xx >> amt);
      end
    endcase
  endfunction

  // Single item: check latency and result
  task automatic one(input string tag, input logic [15:0] x, input logic [3:0] amt,
                     input logic [1:0] m, input logic [15:0] exp);
    int lat;
    bus.x_i = x; bus.amount_i = amt; bus.mode_i = m;
    bus.valid_i = 1'b1; bus.ready_i = 1'b1;
    step();
    bus.valid_i = 1'b0;
    lat = 1;
    while (!bus.valid_o && lat < 10) begin step(); lat++; end
    check({tag, " latency"}, lat, 4);
    check(tag, bus.y_o, exp);
    step();
  endtask

  initial begin
    logic [15:0] sx [16];
    logic [3:0]  sa [16];
    logic [1:0]  sm [16];
    logic [15:0] exp_q [$];
    logic [15:0] held;
    int sent, got, seen;
    logic stalled;

    bus.valid_i = 1'b0; bus.ready_i = 1'b0; bus.x_i = '0; bus.amount_i = '0; bus.mode_i = '0;
    #12;
    check("rst valid_o", bus.valid_o, 0);
    check("rst y_o", bus.y_o, 0);
    check("rst ready_o", bus.ready_o, 1);
    rst = 1'b0;
    step();
    check("post-rst ready_o", bus.ready_o, 1);

    // Directed vectors
    one("ASR 8000>>>3", 16'h8000, 4'd3,  ASR, 16'hF000);
    one("ASR 7FFF>>>15", 16'h7FFF, 4'd15, ASR, E_7FFF);
    one("LSR 8000>>15", 16'h8000, 4'd15, LSR, 16'h0001);
    one("LSL 0001<<15", 16'h0001, 4'd15, LSL, 16'h8000);
    one("ROR 0001 by 1", 16'h0001, 4'd1,  ROR, 16'h8000);
    one("ASR amt0", 16'hA5C3, 4'd0, ASR, 16'hA5C3);
    one("LSR amt0", 16'hA5C3, 4'd0, LSR, 16'hA5C3);
    one("LSL amt0", 16'hA5C3, 4'd0, LSL, 16'hA5C3);
    one("ROR amt0", 16'hA5C3, 4'd0, ROR, 16'hA5C3);
    one("ROR 1234 by 4", 16'h1234, 4'd4, ROR, 16'h4123);
    one("LSL 00FF<<9", 16'h00FF, 4'd9, LSL, 16'hFE00);
    one("ASR 0007>>>1", 16'h0007, 4'd1, ASR, E_0007);
    one("ASR FFFB>>>1", 16'hFFFB, 4'd1, ASR, E_FFFB);

    // Random stream with random downstream stalls
    for (int i = 0; i < 16; i++) begin
      sx[i] = 16'($urandom); sa[i] = 4'($urandom_range(0, 15)); sm[i] = 2'($urandom_range(0, 3));
      exp_q.push_back(model(sx[i], int'(sa[i]), sm[i]));
    end
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 400 && got < 16; c++) begin
      bus.ready_i = 1'($urandom_range(0, 1));
      bus.valid_i = (sent < 16);
      if (sent < 16) begin
        bus.x_i = sx[sent]; bus.amount_i = sa[sent]; bus.mode_i = sm[sent];
      end
      #1;
      if (stalled) begin
        check("stall valid held", bus.valid_o, 1);
        check("stall y held", bus.y_o, held);
      end
      check("ready_o rule", bus.ready_o, !(bus.valid_o && !bus.ready_i));
      if (bus.valid_o && bus.ready_i) begin
        check($sformatf("stream item %0d", got), bus.y_o, exp_q.pop_front());
        got++;
      end
      stalled = bus.valid_o && !bus.ready_i;
      held    = bus.y_o;
      if (bus.valid_i && bus.ready_o) sent++;
      step();
    end
    check("stream count", got, 16);
    bus.valid_i = 1'b0; bus.ready_i = 1'b1;
    repeat (6) step();

    // Asynchronous reset with items in flight
    bus.ready_i = 1'b1; bus.mode_i = ASR; bus.x_i = 16'h8421; bus.amount_i = 4'd1;
    bus.valid_i = 1'b1;
    repeat (3) step();
    bus.valid_i = 1'b0; bus.ready_i = 1'b0;
    repeat (2) step();
    check("pre-reset valid_o", bus.valid_o, 1);
    #2 rst = 1'b1;
    #1;
    check("async rst valid_o", bus.valid_o, 0);
    check("async rst y_o", bus.y_o, 0);
    check("async rst ready_o", bus.ready_o, 1);
    #1 rst = 1'b0;
    bus.ready_i = 1'b1;
    seen = 0;
    repeat (8) begin step(); if (bus.valid_o) seen = 1; end
    check("no stale after rst", seen, 0);

    // Flush with 4 in flight, stalled output and a competing input
    bus.ready_i = 1'b1; bus.mode_i = LSR; bus.amount_i = 4'd4; bus.valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.x_i = 16'h1000 * 16'(i + 1);
      step();
    end
    check("pre-flush valid_o", bus.valid_o, 1);
    bus.ready_i = 1'b0; flush = 1'b1; bus.x_i = 16'h5555; bus.amount_i = 4'd1;
    step();
    flush = 1'b0; bus.valid_i = 1'b0; bus.ready_i = 1'b1;
    check("flush valid_o", bus.valid_o, 0);
    check("flush ready_o", bus.ready_o, 1);
    seen = 0;
    repeat (6) begin step(); if (bus.valid_o) seen = 1; end
    check("flushed input dropped", seen, 0);
    one("post-flush LSR", 16'h00F0, 4'd4, LSR, 16'h000F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
